// File: rtl/apb_bridge_pkg.sv
// ---------------------------------------------------------------
// apb_bridge_pkg : shared types and constants for the APB bridge
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package apb_bridge_pkg;

  localparam int SLOT_BITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/apb_bridge_wdog.sv
// ---------------------------------------------------------------
// apb_bridge_wdog : counts stalled ACCESS cycles, flags expiry
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module apb_bridge_wdog #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_disabled
      logic unused_ok;
      assign unused_ok = ^{clk, rst, clear, count_en};
      assign expired   = 1'b0;
    end else begin : g_enabled
      localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
          cnt_d = '0;
        end else if (count_en) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // Fires on the TIMEOUT-th stalled cycle itself, so the abort lands right after it
      assign expired = count_en && (cnt_q == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/apb_bridge_sync.sv
// ---------------------------------------------------------------
// apb_bridge_sync : single-clock APB-to-APB bridge with slot decode
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module apb_bridge_sync
  import apb_bridge_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NSLV    = 16,
  parameter int SEL_LSB = 24,
  parameter int TIMEOUT = 256
) (
  input  logic            PCLK,
  input  logic            PRESET,
  input  logic            PSEL_PM,
  input  logic            PENABLE_PM,
  input  logic [AW-1:0]   PADDR_PM,
  input  logic            PWRITE_PM,
  input  logic [DW-1:0]   PWDATA_PM,
  output logic [DW-1:0]   PRDATA_PM,
  output logic            PREADY_PM,
  output logic            PSLVERR_PM,
  output logic [NSLV-1:0] PSEL_SC,
  output logic [AW-1:0]   PADDR_SC,
  output logic            PWRITE_SC,
  output logic            PENABLE_SC,
  output logic [DW-1:0]   PWDATA_SC,
  input  logic [DW-1:0]   PRDATA_SC,
  input  logic            PREADY_SC,
  input  logic            PSLVERR_SC,
  output logic            TIMEOUT_EV
);

  state_e          state_q, state_d;
  logic [NSLV-1:0] psel_sc_q, psel_sc_d;
  logic            penable_sc_q, penable_sc_d;
  logic [AW-1:0]   paddr_sc_q, paddr_sc_d;
  logic [DW-1:0]   pwdata_sc_q, pwdata_sc_d;
  logic            pwrite_sc_q, pwrite_sc_d;
  logic            pready_pm_q, pready_pm_d;
  logic            pslverr_pm_q, pslverr_pm_d;
  logic [DW-1:0]   prdata_pm_q, prdata_pm_d;
  logic            timeout_ev_q, timeout_ev_d;

  logic [SLOT_BITS-1:0] w_slot;
  logic                 w_slot_hit;
  logic [NSLV-1:0]      w_onehot;
  logic                 w_expired;
  logic                 w_drop_sc;

  assign w_slot     = PADDR_PM[SEL_LSB +: SLOT_BITS];
  assign w_slot_hit = ({1'b0, w_slot} < (SLOT_BITS + 1)'(NSLV));

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NSLV; i++) begin
      w_onehot[i] = (w_slot == SLOT_BITS'(i));
    end
  end

  apb_bridge_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk      (PCLK),
    .rst      (PRESET),
    .clear    (state_q != ST_ACCESS),
    .count_en ((state_q == ST_ACCESS) && !PREADY_SC),
    .expired  (w_expired)
  );

  // The downstream output registers double as the transfer latches
  always_comb begin
    state_d      = state_q;
    psel_sc_d    = psel_sc_q;
    penable_sc_d = penable_sc_q;
    paddr_sc_d   = paddr_sc_q;
    pwdata_sc_d  = pwdata_sc_q;
    pwrite_sc_d  = pwrite_sc_q;
    pready_pm_d  = 1'b0;
    pslverr_pm_d = 1'b0;
    prdata_pm_d  = '0;
    timeout_ev_d = 1'b0;
    w_drop_sc    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (PSEL_PM && PENABLE_PM) begin
          if (w_slot_hit) begin
            state_d     = ST_SETUP;
            psel_sc_d   = w_onehot;
            paddr_sc_d  = PADDR_PM;
            pwdata_sc_d = PWDATA_PM;
            pwrite_sc_d = PWRITE_PM;
          end else begin
            state_d      = ST_RESP;
            pready_pm_d  = 1'b1;
            pslverr_pm_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        state_d      = ST_ACCESS;
        penable_sc_d = 1'b1;
      end
      ST_ACCESS: begin
        if (PREADY_SC) begin
          state_d      = ST_RESP;
          pready_pm_d  = 1'b1;
          pslverr_pm_d = PSLVERR_SC;
          prdata_pm_d  = pwrite_sc_q ? '0 : PRDATA_SC;
          w_drop_sc    = 1'b1;
        end else if (w_expired) begin
          state_d      = ST_RESP;
          pready_pm_d  = 1'b1;
          pslverr_pm_d = 1'b1;
          timeout_ev_d = 1'b1;
          w_drop_sc    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_drop_sc) begin
      psel_sc_d    = '0;
      penable_sc_d = 1'b0;
      paddr_sc_d   = '0;
      pwdata_sc_d  = '0;
      pwrite_sc_d  = 1'b0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q      <= ST_IDLE;
      psel_sc_q    <= '0;
      penable_sc_q <= 1'b0;
      paddr_sc_q   <= '0;
      pwdata_sc_q  <= '0;
      pwrite_sc_q  <= 1'b0;
      pready_pm_q  <= 1'b0;
      pslverr_pm_q <= 1'b0;
      prdata_pm_q  <= '0;
      timeout_ev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      psel_sc_q    <= psel_sc_d;
      penable_sc_q <= penable_sc_d;
      paddr_sc_q   <= paddr_sc_d;
      pwdata_sc_q  <= pwdata_sc_d;
      pwrite_sc_q  <= pwrite_sc_d;
      pready_pm_q  <= pready_pm_d;
      pslverr_pm_q <= pslverr_pm_d;
      prdata_pm_q  <= prdata_pm_d;
      timeout_ev_q <= timeout_ev_d;
    end
  end

  assign PSEL_SC    = psel_sc_q;
  assign PENABLE_SC = penable_sc_q;
  assign PADDR_SC   = paddr_sc_q;
  assign PWDATA_SC  = pwdata_sc_q;
  assign PWRITE_SC  = pwrite_sc_q;
  assign PREADY_PM  = pready_pm_q;
  assign PSLVERR_PM = pslverr_pm_q;
  assign PRDATA_PM  = prdata_pm_q;
  assign TIMEOUT_EV = timeout_ev_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_bridge_sync.sv
// ---------------------------------------------------------------
// tb_apb_bridge_sync : directed self-checking bench for apb_bridge_sync
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_apb_bridge_sync;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        PSEL_PM, PENABLE_PM, PWRITE_PM;
  logic [31:0] PADDR_PM, PWDATA_PM, PRDATA_PM;
  logic        PREADY_PM, PSLVERR_PM;
  logic [3:0]  PSEL_SC;
  logic [31:0] PADDR_SC, PWDATA_SC, PRDATA_SC;
  logic        PWRITE_SC, PENABLE_SC, PREADY_SC, PSLVERR_SC, TIMEOUT_EV;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 PCLK = ~PCLK;

  apb_bridge_sync #(
    .AW(32), .DW(32), .NSLV(4), .SEL_LSB(24), .TIMEOUT(8)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .PSEL_PM(PSEL_PM), .PENABLE_PM(PENABLE_PM), .PADDR_PM(PADDR_PM),
    .PWRITE_PM(PWRITE_PM), .PWDATA_PM(PWDATA_PM), .PRDATA_PM(PRDATA_PM),
    .PREADY_PM(PREADY_PM), .PSLVERR_PM(PSLVERR_PM),
    .PSEL_SC(PSEL_SC), .PADDR_SC(PADDR_SC), .PWRITE_SC(PWRITE_SC),
    .PENABLE_SC(PENABLE_SC), .PWDATA_SC(PWDATA_SC), .PRDATA_SC(PRDATA_SC),
    .PREADY_SC(PREADY_SC), .PSLVERR_SC(PSLVERR_SC), .TIMEOUT_EV(TIMEOUT_EV)
  );

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle_upstream();
    PSEL_PM = 1'b0; PENABLE_PM = 1'b0; PWRITE_PM = 1'b0;
    PADDR_PM = '0; PWDATA_PM = '0;
  endtask

  task automatic test_reset();
    idle_upstream();
    PRDATA_SC = 32'h0; PREADY_SC = 1'b0; PSLVERR_SC = 1'b0;
    PRESET = 1'b1;
    tick(); tick();
    n_checks++; if (PSEL_SC !== 4'h0 || PENABLE_SC !== 1'b0) $display("FAIL rst_sc: got psel %h en %b want 0 0", PSEL_SC, PENABLE_SC); else n_pass++;
    n_checks++; if (PADDR_SC !== 32'h0 || PWDATA_SC !== 32'h0 || PWRITE_SC !== 1'b0) $display("FAIL rst_sc_bus: got %h %h %b want 0", PADDR_SC, PWDATA_SC, PWRITE_SC); else n_pass++;
    n_checks++; if (PREADY_PM !== 1'b0 || PSLVERR_PM !== 1'b0 || PRDATA_PM !== 32'h0 || TIMEOUT_EV !== 1'b0) $display("FAIL rst_pm: got %b %b %h %b want 0", PREADY_PM, PSLVERR_PM, PRDATA_PM, TIMEOUT_EV); else n_pass++;
    PRESET = 1'b0;
    tick();
  endtask

  task automatic test_write_zero_wait();
    // APB setup phase: not yet an access, must be ignored
    PSEL_PM = 1'b1; PENABLE_PM = 1'b0; PWRITE_PM = 1'b1;
    PADDR_PM = 32'h0300_0010; PWDATA_PM = 32'hA5A5_5A5A;
    PREADY_SC = 1'b1; PRDATA_SC = 32'hDEAD_BEEF; PSLVERR_SC = 1'b0;
    tick();
    n_checks++; if (PSEL_SC !== 4'h0) $display("FAIL wr_setup_ignored: got %h want 0", PSEL_SC); else n_pass++;
    PENABLE_PM = 1'b1;
    tick();
    n_checks++; if (PSEL_SC !== 4'h8 || PENABLE_SC !== 1'b0) $display("FAIL wr_setup: got psel %h en %b want 8 0", PSEL_SC, PENABLE_SC); else n_pass++;
    n_checks++; if (PADDR_SC !== 32'h0300_0010 || PWDATA_SC !== 32'hA5A5_5A5A || PWRITE_SC !== 1'b1) $display("FAIL wr_bus: got %h %h %b want 03000010 a5a55a5a 1", PADDR_SC, PWDATA_SC, PWRITE_SC); else n_pass++;
    tick();
    n_checks++; if (PSEL_SC !== 4'h8 || PENABLE_SC !== 1'b1 || PREADY_PM !== 1'b0) $display("FAIL wr_access: got psel %h en %b rdy %b want 8 1 0", PSEL_SC, PENABLE_SC, PREADY_PM); else n_pass++;
    tick();
    n_checks++; if (PREADY_PM !== 1'b1 || PSLVERR_PM !== 1'b0 || PRDATA_PM !== 32'h0) $display("FAIL wr_resp: got rdy %b err %b data %h want 1 0 0", PREADY_PM, PSLVERR_PM, PRDATA_PM); else n_pass++;
    n_checks++; if (PSEL_SC !== 4'h0 || PENABLE_SC !== 1'b0 || PADDR_SC !== 32'h0) $display("FAIL wr_resp_sc: got %h %b %h want 0", PSEL_SC, PENABLE_SC, PADDR_SC); else n_pass++;
    idle_upstream();
    tick();
    n_checks++; if (PREADY_PM !== 1'b0) $display("FAIL wr_idle_rdy: got %b want 0", PREADY_PM); else n_pass++;
  endtask

  task automatic test_read_wait();
    PSEL_PM = 1'b1; PENABLE_PM = 1'b1; PWRITE_PM = 1'b0; PADDR_PM = 32'h0100_0000;
    PREADY_SC = 1'b0; PRDATA_SC = 32'h1234_5678;
    tick();
    n_checks++; if (PSEL_SC !== 4'h2 || PWRITE_SC !== 1'b0) $display("FAIL rd_setup: got psel %h wr %b want 2 0", PSEL_SC, PWRITE_SC); else n_pass++;
    tick();
    tick();
    n_checks++; if (PENABLE_SC !== 1'b1 || PREADY_PM !== 1'b0 || PRDATA_PM !== 32'h0) $display("FAIL rd_wait1: got en %b rdy %b data %h want 1 0 0", PENABLE_SC, PREADY_PM, PRDATA_PM); else n_pass++;
    tick();
    n_checks++; if (PSEL_SC !== 4'h2 || PREADY_PM !== 1'b0) $display("FAIL rd_wait2: got psel %h rdy %b want 2 0", PSEL_SC, PREADY_PM); else n_pass++;
    PREADY_SC = 1'b1;
    tick();
    n_checks++; if (PREADY_PM !== 1'b1 || PRDATA_PM !== 32'h1234_5678 || PSLVERR_PM !== 1'b0) $display("FAIL rd_resp: got rdy %b data %h err %b want 1 12345678 0", PREADY_PM, PRDATA_PM, PSLVERR_PM); else n_pass++;
    idle_upstream(); PREADY_SC = 1'b0;
    tick();
    n_checks++; if (PRDATA_PM !== 32'h0 || PREADY_PM !== 1'b0) $display("FAIL rd_after: got data %h rdy %b want 0 0", PRDATA_PM, PREADY_PM); else n_pass++;
  endtask

  task automatic test_unmapped();
    PSEL_PM = 1'b1; PENABLE_PM = 1'b1; PWRITE_PM = 1'b0; PADDR_PM = 32'h0500_0000;
    PREADY_SC = 1'b1; PRDATA_SC = 32'h5555_AAAA;
    tick();
    n_checks++; if (PREADY_PM !== 1'b1 || PSLVERR_PM !== 1'b1 || PRDATA_PM !== 32'h0) $display("FAIL unm_resp: got rdy %b err %b data %h want 1 1 0", PREADY_PM, PSLVERR_PM, PRDATA_PM); else n_pass++;
    n_checks++; if (PSEL_SC !== 4'h0 || PENABLE_SC !== 1'b0) $display("FAIL unm_sc: got psel %h en %b want 0 0", PSEL_SC, PENABLE_SC); else n_pass++;
    idle_upstream(); PREADY_SC = 1'b0;
    tick();
    n_checks++; if (PREADY_PM !== 1'b0 || PSLVERR_PM !== 1'b0 || PSEL_SC !== 4'h0) $display("FAIL unm_idle: got %b %b %h want 0 0 0", PREADY_PM, PSLVERR_PM, PSEL_SC); else n_pass++;
  endtask

  task automatic test_timeout();
    int ev_seen = 0;
    PSEL_PM = 1'b1; PENABLE_PM = 1'b1; PWRITE_PM = 1'b0; PADDR_PM = 32'h0200_0004;
    PREADY_SC = 1'b0; PRDATA_SC = 32'hFFFF_0000;
    tick();
    tick();
    // Upstream drops its select; the downstream transfer must carry on
    idle_upstream();
    for (int i = 0; i < 7; i++) begin
      tick();
      ev_seen += int'(TIMEOUT_EV);
      n_checks++; if (PENABLE_SC !== 1'b1 || PSEL_SC !== 4'h4 || PREADY_PM !== 1'b0) $display("FAIL to_wait%0d: got en %b psel %h rdy %b want 1 4 0", i, PENABLE_SC, PSEL_SC, PREADY_PM); else n_pass++;
    end
    tick();
    ev_seen += int'(TIMEOUT_EV);
    n_checks++; if (PREADY_PM !== 1'b1 || PSLVERR_PM !== 1'b1 || PRDATA_PM !== 32'h0 || TIMEOUT_EV !== 1'b1) $display("FAIL to_resp: got rdy %b err %b data %h ev %b want 1 1 0 1", PREADY_PM, PSLVERR_PM, PRDATA_PM, TIMEOUT_EV); else n_pass++;
    n_checks++; if (PSEL_SC !== 4'h0 || PENABLE_SC !== 1'b0) $display("FAIL to_resp_sc: got %h %b want 0 0", PSEL_SC, PENABLE_SC); else n_pass++;
    tick();
    ev_seen += int'(TIMEOUT_EV);
    tick();
    ev_seen += int'(TIMEOUT_EV);
    n_checks++; if (ev_seen !== 1) $display("FAIL to_ev_count: got %0d want 1", ev_seen); else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    PSEL_PM = 1'b1; PENABLE_PM = 1'b1; PWRITE_PM = 1'b1;
    PADDR_PM = 32'h0100_0020; PWDATA_PM = 32'h0BAD_F00D; PREADY_SC = 1'b0;
    tick();
    tick();
    n_checks++; if (PENABLE_SC !== 1'b1 || PSEL_SC !== 4'h2) $display("FAIL rm_access: got en %b psel %h want 1 2", PENABLE_SC, PSEL_SC); else n_pass++;
    #2;
    PRESET = 1'b1;
    #1;
    n_checks++; if (PSEL_SC !== 4'h0 || PENABLE_SC !== 1'b0 || PADDR_SC !== 32'h0 || PWDATA_SC !== 32'h0 || PWRITE_SC !== 1'b0) $display("FAIL rm_sc_zero: got %h %b %h %h %b want 0", PSEL_SC, PENABLE_SC, PADDR_SC, PWDATA_SC, PWRITE_SC); else n_pass++;
    idle_upstream();
    tick();
    PRESET = 1'b0;
    tick();
    PSEL_PM = 1'b1; PENABLE_PM = 1'b1; PWRITE_PM = 1'b1;
    PADDR_PM = 32'h0000_0008; PWDATA_PM = 32'h1111_2222; PREADY_SC = 1'b1;
    tick();
    n_checks++; if (PSEL_SC !== 4'h1 || PWDATA_SC !== 32'h1111_2222) $display("FAIL rm_next_setup: got psel %h wd %h want 1 11112222", PSEL_SC, PWDATA_SC); else n_pass++;
    tick();
    tick();
    n_checks++; if (PREADY_PM !== 1'b1 || PSLVERR_PM !== 1'b0) $display("FAIL rm_next_resp: got rdy %b err %b want 1 0", PREADY_PM, PSLVERR_PM); else n_pass++;
    idle_upstream(); PREADY_SC = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    PSEL_PM = 1'b1; PENABLE_PM = 1'b1; PWRITE_PM = 1'b1;
    PADDR_PM = 32'h0200_0000; PWDATA_PM = 32'h7777_8888;
    PREADY_SC = 1'b1; PSLVERR_SC = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (PREADY_PM !== 1'b1 || PSLVERR_PM !== 1'b1) $display("FAIL b2b_first: got rdy %b err %b want 1 1", PREADY_PM, PSLVERR_PM); else n_pass++;
    // Second request presented during RESP; only the following IDLE cycle may take it
    PWRITE_PM = 1'b0; PADDR_PM = 32'h0000_0000;
    PSLVERR_SC = 1'b0; PRDATA_SC = 32'hCAFE_F00D;
    tick();
    n_checks++; if (PSEL_SC !== 4'h0 || PREADY_PM !== 1'b0 || PSLVERR_PM !== 1'b0) $display("FAIL b2b_gap: got psel %h rdy %b err %b want 0 0 0", PSEL_SC, PREADY_PM, PSLVERR_PM); else n_pass++;
    tick();
    n_checks++; if (PSEL_SC !== 4'h1 || PENABLE_SC !== 1'b0) $display("FAIL b2b_setup: got psel %h en %b want 1 0", PSEL_SC, PENABLE_SC); else n_pass++;
    tick(); tick();
    n_checks++; if (PREADY_PM !== 1'b1 || PRDATA_PM !== 32'hCAFE_F00D || PSLVERR_PM !== 1'b0) $display("FAIL b2b_second: got rdy %b data %h err %b want 1 cafef00d 0", PREADY_PM, PRDATA_PM, PSLVERR_PM); else n_pass++;
    idle_upstream(); PREADY_SC = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_unmapped();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_time_limit: got timeout want completion");
    $fatal(1, "simulation time limit");
  end

endmodule

`default_nettype wire

// File: doc/apb_bridge_sync.md
APB_BRIDGE_SYNC -- requirements
Module: apb_bridge_sync
Interface
REQ-001 SHALL use one clock, PCLK; reset PRESET is asynchronous and active-high.
REQ-002 Parameter AW, default 32, is the address width on both ports.
REQ-003 Parameter DW, default 32, is the data width on both ports.
REQ-004 Parameter NSLV, default 16, legal 1..16, is the number of downstream slave selects.
REQ-005 Parameter SEL_LSB, default 24, is the LSB of the 4-bit slot field PADDR_PM[SEL_LSB+3:SEL_LSB]; requires SEL_LSB+3 < AW.
REQ-006 Parameter TIMEOUT, default 256, is the number of ACCESS cycles allowed per transfer; 0 disables the timeout.
REQ-007 PCLK  in  1  clock for all logic.
REQ-008 PRESET  in  1  asynchronous active-high reset.
REQ-009 PSEL_PM  in  1  upstream select.
REQ-010 PENABLE_PM  in  1  upstream enable.
REQ-011 PADDR_PM  in  AW  upstream address.
REQ-012 PWRITE_PM  in  1  upstream direction, 1 = write.
REQ-013 PWDATA_PM  in  DW  upstream write data.
REQ-014 PRDATA_PM  out  DW  upstream read data.
REQ-015 PREADY_PM  out  1  upstream completion.
REQ-016 PSLVERR_PM  out  1  upstream error.
REQ-017 PSEL_SC  out  NSLV  one-hot downstream select.
REQ-018 PADDR_SC  out  AW  downstream address.
REQ-019 PWRITE_SC  out  1  downstream direction.
REQ-020 PENABLE_SC  out  1  downstream enable.
REQ-021 PWDATA_SC  out  DW  downstream write data.
REQ-022 PRDATA_SC  in  DW  downstream read data, shared by all slots.
REQ-023 PREADY_SC  in  1  downstream ready.
REQ-024 PSLVERR_SC  in  1  downstream error.
REQ-025 TIMEOUT_EV  out  1  one-cycle pulse on each timeout abort.
Function
REQ-026 FSM states SHALL be IDLE, SETUP, ACCESS and RESP; all outputs are registered.
REQ-027 IDLE: when PSEL_PM=1 and PENABLE_PM=1, latch address, write data and direction; if slot < NSLV go to SETUP, else go to RESP with error=1 and data=0, with no downstream transfer.
REQ-028 SETUP (1 cycle): PSEL_SC[slot]=1, PENABLE_SC=0, PADDR_SC/PWDATA_SC/PWRITE_SC driven from the latched values; then go to ACCESS.
REQ-029 ACCESS: PENABLE_SC=1 and the select stays held; when PREADY_SC=1, capture PRDATA_SC (reads only, 0 for writes) and PSLVERR_SC, then go to RESP.
REQ-030 Timeout: count ACCESS cycles with PREADY_SC=0; when the count reaches TIMEOUT, go to RESP with error=1 and data=0, and pulse TIMEOUT_EV; PREADY_SC=1 in the same cycle wins.
REQ-031 RESP (1 cycle): PREADY_PM=1 with PRDATA_PM/PSLVERR_PM valid; all downstream outputs are 0; then go to IDLE.
REQ-032 Outside RESP: PREADY_PM, PSLVERR_PM and PRDATA_PM are 0; outside SETUP/ACCESS: PSEL_SC, PENABLE_SC, PADDR_SC, PWDATA_SC and PWRITE_SC are 0.
REQ-033 Latency with a zero-wait slave: PREADY_PM is asserted 3 cycles after the first upstream access cycle; for an unmapped slot, 1 cycle.
REQ-034 Upstream inputs are ignored outside IDLE; dropping PSEL_PM mid-transfer does not abort the downstream transfer.
REQ-035 Back-to-back transfers: the next transfer is accepted from IDLE one cycle after RESP; no pipelining.
Reset
REQ-036 PRESET asserted at any time, including mid-transfer, SHALL force IDLE, clear the timeout counter and latches, and drive every output to 0 immediately.
REQ-037 After PRESET deasserts, the first transfer is accepted on the next qualifying IDLE cycle.
Structure
REQ-038 Package apb_bridge_pkg SHALL hold the state enum and SLOT_BITS=4.
REQ-039 Timeout counter SHALL be sub-module apb_bridge_wdog (ports: clear, count-enable, expired), with width sized from TIMEOUT.
Verification
REQ-040 Write 0x0300_0010 data 0xA5A5_5A5A, slave 3 zero-wait -> PSEL_SC=0x0008 for 2 cycles, PREADY_PM at access cycle 3, PSLVERR_PM=0.
REQ-041 Read 0x0100_0000, slave 1 with 2 wait states, PRDATA_SC=0x1234_5678 -> PRDATA_PM=0x1234_5678 in the RESP cycle only.
REQ-042 NSLV=4, address 0x0500_0000 -> PSEL_SC stays 0, PREADY_PM=1 and PSLVERR_PM=1 after 1 cycle.
REQ-043 TIMEOUT=8, PREADY_SC held 0 -> abort after 8 ACCESS cycles, PSLVERR_PM=1, PRDATA_PM=0, TIMEOUT_EV pulses once.
REQ-044 PRESET pulsed during ACCESS -> all outputs 0 in the same cycle; the next transfer completes normally.
